// File: rtl/hins_uart_pkg.sv
// rtl/hins_uart_pkg.sv - shared types and constants for the UART packet transmitter
package hins_uart_pkg;

  typedef enum logic [1:0] {PKT_IDLE, PKT_SEND, PKT_NEXT, PKT_DONE} pkt_state_t;
  typedef enum logic [1:0] {BT_IDLE, BT_START, BT_DATA, BT_STOP} byte_state_t;

  localparam logic [7:0] HDR_BYTE_DEF    = 8'hC0;
  localparam int         PKT_BYTES_BASE  = 10;
  localparam int         PKT_BYTES_CKSUM = 11;
  localparam int         MIN_BAUD_DIV    = 4;

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 byte serialiser with byte-valid/byte-done handshake
// o_byte_done fires one clock before the stop bit ends so the next byte can follow back-to-back.
module uart_byte_tx
  import hins_uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte_data,
  output logic             o_byte_done,
  output logic             o_tx
);

  byte_state_t      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic [DIV_W-1:0] div_m1, div_m2;
  logic             bit_end;

  assign div_m1  = i_div - DIV_W'(1);
  assign div_m2  = i_div - DIV_W'(2);
  assign bit_end = (cnt_q == div_m1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= BT_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    o_byte_done = 1'b0;
    case (state_q)
      BT_IDLE: begin
        if (i_byte_valid) begin
          state_d = BT_START;
          cnt_d   = '0;
          bit_d   = '0;
          sh_d    = i_byte_data;
        end
      end
      BT_START: begin
        if (bit_end) begin
          state_d = BT_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      BT_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = BT_STOP;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      BT_STOP: begin
        o_byte_done = (cnt_q == div_m2);
        if (bit_end) begin
          cnt_d = '0;
          // a byte offered on the last stop clock starts with no idle gap
          if (i_byte_valid) begin
            state_d = BT_START;
            bit_d   = '0;
            sh_d    = i_byte_data;
          end else begin
            state_d = BT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = BT_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      BT_START: o_tx = 1'b0;
      BT_DATA:  o_tx = sh_q[0];
      default:  o_tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/hins_uart_pkt_tx.sv
// rtl/hins_uart_pkt_tx.sv - framed UART packet sender: two headers, two payload words
// Define HINS_UART_PKT_CKSUM_EN to append a modulo-256 payload checksum byte.
module hins_uart_pkt_tx
  import hins_uart_pkg::*;
#(
  parameter int         BAUD_DIV_W = 16,
  parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_trig,
  input  logic [31:0]           i_data0,
  input  logic [31:0]           i_data1,
  input  logic [BAUD_DIV_W-1:0] i_baud_div,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_drop_cnt
);

`ifdef HINS_UART_PKT_CKSUM_EN
  localparam int N_BYTES = PKT_BYTES_CKSUM;
`else
  localparam int N_BYTES = PKT_BYTES_BASE;
`endif
  localparam logic [3:0] LAST_IDX = 4'(N_BYTES - 1);

  pkt_state_t            state_q, state_d;
  logic [3:0]            idx_q, idx_d, idx_n;
  logic [31:0]           d0_q, d1_q;
  logic [BAUD_DIV_W-1:0] div_q, div_eff;
  logic [15:0]           drop_q;
  logic                  accept, byte_valid, byte_done, bt_tx;
  logic [7:0]            byte_data, next_byte;

  assign accept  = (state_q == PKT_IDLE) && i_trig;
  assign idx_n   = idx_q + 4'd1;
  assign div_eff = (i_baud_div < BAUD_DIV_W'(MIN_BAUD_DIV)) ?
                   BAUD_DIV_W'(MIN_BAUD_DIV) : i_baud_div;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= PKT_IDLE;
      idx_q   <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      div_q   <= BAUD_DIV_W'(MIN_BAUD_DIV);
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        d0_q  <= i_data0;
        d1_q  <= i_data1;
        div_q <= div_eff;
      end
      if (i_trig && state_q != PKT_IDLE && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    byte_valid = 1'b0;
    case (state_q)
      PKT_IDLE: begin
        if (i_trig) begin
          state_d    = PKT_SEND;
          idx_d      = '0;
          byte_valid = 1'b1;
        end
      end
      PKT_SEND: if (byte_done) state_d = PKT_NEXT;
      PKT_NEXT: begin
        // coincides with the last stop-bit clock of the current byte
        if (idx_q == LAST_IDX) begin
          state_d = PKT_DONE;
        end else begin
          state_d    = PKT_SEND;
          idx_d      = idx_n;
          byte_valid = 1'b1;
        end
      end
      PKT_DONE: state_d = PKT_IDLE;
      default:  state_d = PKT_IDLE;
    endcase
  end

`ifdef HINS_UART_PKT_CKSUM_EN
  logic [7:0] cksum;
  assign cksum = d0_q[31:24] + d0_q[23:16] + d0_q[15:8] + d0_q[7:0] +
                 d1_q[31:24] + d1_q[23:16] + d1_q[15:8] + d1_q[7:0];
`endif

  always_comb begin
    next_byte = HDR_BYTE;
    case (idx_n)
      4'd2:    next_byte = d0_q[31:24];
      4'd3:    next_byte = d0_q[23:16];
      4'd4:    next_byte = d0_q[15:8];
      4'd5:    next_byte = d0_q[7:0];
      4'd6:    next_byte = d1_q[31:24];
      4'd7:    next_byte = d1_q[23:16];
      4'd8:    next_byte = d1_q[15:8];
      4'd9:    next_byte = d1_q[7:0];
`ifdef HINS_UART_PKT_CKSUM_EN
      4'd10:   next_byte = cksum;
`endif
      default: next_byte = HDR_BYTE;
    endcase
  end

  // the first header is a constant, so it can go out before the payload is registered
  assign byte_data = accept ? HDR_BYTE : next_byte;

  uart_byte_tx #(
    .DIV_W (BAUD_DIV_W)
  ) u_byte_tx (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_div        (div_q),
    .i_byte_valid (byte_valid),
    .i_byte_data  (byte_data),
    .o_byte_done  (byte_done),
    .o_tx         (bt_tx)
  );

  assign o_tx       = (state_q == PKT_IDLE) ? 1'b1 : bt_tx;
  assign o_busy     = (state_q != PKT_IDLE);
  assign o_done     = (state_q == PKT_DONE);
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_hins_uart_pkt_tx.sv
// tb/tb_hins_uart_pkt_tx.sv - self-checking bench for hins_uart_pkt_tx
module tb_hins_uart_pkt_tx;

  localparam int W = 16;
`ifdef HINS_UART_PKT_CKSUM_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_trig = 1'b0;
  logic [31:0]  i_data0 = '0;
  logic [31:0]  i_data1 = '0;
  logic [W-1:0] i_baud_div = W'(4);
  logic         o_tx, o_busy, o_done;
  logic [15:0]  o_drop_cnt;

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [31:0]  d0;
    logic [31:0]  d1;
    logic [W-1:0] div;
    int           eff;
    logic [7:0]   cks;
  } vec_t;
  vec_t vecs[5];

  always #5 i_clk = ~i_clk;

  hins_uart_pkt_tx #(.BAUD_DIV_W(W), .HDR_BYTE(8'hC0)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_trig     (i_trig),
    .i_data0    (i_data0),
    .i_data1    (i_data1),
    .i_baud_div (i_baud_div),
    .o_tx       (o_tx),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_drop_cnt (o_drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_expected(input vec_t v);
    sb.push_back(8'hC0);
    sb.push_back(8'hC0);
    for (int i = 3; i >= 0; i--) sb.push_back(v.d0[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) sb.push_back(v.d1[i*8 +: 8]);
    if (NB == 11) sb.push_back(v.cks);
  endtask

  // Called on a falling edge; mode 1 injects rejected triggers, mode 2 disturbs inputs mid-packet.
  task automatic run_pkt(input vec_t v, input int mode);
    int eff, total, c, p, b;
    logic cur;
    logic [7:0] shv, exp_b;
    bit unstable, busy_bad;
    eff = v.eff;
    total = NB * 10 * eff;
    cur = 1'b1;
    shv = '0;
    unstable = 0;
    busy_bad = 0;
    push_expected(v);
    chk("pre_busy", o_busy, 0);
    chk("pre_tx", o_tx, 1);
    i_trig = 1'b1;
    i_data0 = v.d0;
    i_data1 = v.d1;
    i_baud_div = v.div;
    @(negedge i_clk);
    i_trig = 1'b0;
    for (int s = 1; s <= total; s++) begin
      if (!o_busy || o_done) busy_bad = 1;
      c = (s - 1) % eff;
      p = (s - 1) / eff;
      b = p % 10;
      if (c == 0) cur = o_tx;
      else if (o_tx !== cur) unstable = 1;
      if (c == eff - 1) begin
        if (b == 0) chk("start_bit", cur, 0);
        else if (b <= 8) shv[b-1] = cur;
        else begin
          chk("stop_bit", cur, 1);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL byte: got %h expected none (scoreboard empty)", shv);
          end else begin
            exp_b = sb.pop_front();
            chk("byte", shv, exp_b);
          end
        end
      end
      if (mode == 1 && s == 50) begin
        i_trig = 1'b1;
        exp_drop++;
      end
      if (mode == 1 && s == 51) i_trig = 1'b0;
      if (mode == 2 && s == 30) begin
        i_data0 = ~v.d0;
        i_baud_div = v.div + W'(3);
      end
      @(negedge i_clk);
    end
    chk("done_pulse", o_done, 1);
    chk("done_busy", o_busy, 1);
    chk("done_tx", o_tx, 1);
    if (mode == 1) begin
      i_trig = 1'b1;
      exp_drop++;
    end
    @(negedge i_clk);
    i_trig = 1'b0;
    chk("busy_clear", o_busy, 0);
    chk("done_clear", o_done, 0);
    chk("idle_tx", o_tx, 1);
    chk("busy_during", 32'(busy_bad), 0);
    chk("bit_stable", 32'(unstable), 0);
    chk("drop_cnt", o_drop_cnt, exp_drop);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    vecs[0] = '{32'h00000001, 32'hFFFFFFFF, W'(4), 4, 8'hFD};
    vecs[1] = '{32'h12345678, 32'h9ABCDEF0, W'(5), 5, 8'h38};
    vecs[2] = '{32'h00000000, 32'h00000000, W'(1), 4, 8'h00};
    vecs[3] = '{32'hA5A5A5A5, 32'h5A5A5A5A, W'(0), 4, 8'hFC};
    vecs[4] = '{32'hDEADBEEF, 32'h00C0FFEE, W'(7), 7, 8'hE5};

    repeat (3) @(negedge i_clk);
    chk("rst_tx", o_tx, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_drop", o_drop_cnt, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 5; i++) run_pkt(vecs[i], 0);
    run_pkt(vecs[0], 1);
    run_pkt(vecs[4], 2);

    // reset in the middle of payload byte 5
    i_trig = 1'b1;
    i_data0 = vecs[3].d0;
    i_data1 = vecs[3].d1;
    i_baud_div = vecs[3].div;
    @(negedge i_clk);
    i_trig = 1'b0;
    repeat (5 * 10 * 4 + 12) @(negedge i_clk);
    chk("mid_busy", o_busy, 1);
    i_rst_n = 1'b0;
    #1;
    chk("abort_tx", o_tx, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_drop", o_drop_cnt, 0);
    exp_drop = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("post_rst_tx", o_tx, 1);
    chk("post_rst_busy", o_busy, 0);
    run_pkt(vecs[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
